// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl_pkg
// Purpose  : Shared definitions for the conv kernel-loop sequencer:
//            default address widths, configuration field widths and the
//            sequencer state encoding.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

  localparam int AW_DEF = 12;  // input-buffer address width
  localparam int WW_DEF = 10;  // weight address width
  localparam int CH_W   = 4;   // channel count field (id)
  localparam int SIDE_W = 5;   // side-length fields (is, os)
  localparam int KS_W   = 3;   // kernel side field (ks)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/core_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl_if
// Purpose  : Bundles the batch_ctrl handshake, out_ctrl back-pressure,
//            layer configuration and MAC-array address bus of core_ctrl.
// Ports    : slave  - the sequencer (drives exec/k_init/k_fin/ia/wa/s_fin/busy)
//            master - the environment (drives s_init/out_busy/id/is/ks/os)
// Revision : 1.0 - initial release
// ============================================================================
interface core_ctrl_if
  import core_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int WW = WW_DEF
);

  logic              s_init;
  logic              s_fin;
  logic              out_busy;
  logic              exec;
  logic              k_init;
  logic              k_fin;
  logic [AW-1:0]     ia;
  logic [WW-1:0]     wa;
  logic [CH_W-1:0]   id;
  logic [SIDE_W-1:0] is;
  logic [KS_W-1:0]   ks;
  logic [SIDE_W-1:0] os;
  logic              busy;

  modport slave (
    input  s_init, out_busy, id, is, ks, os,
    output s_fin, exec, k_init, k_fin, ia, wa, busy
  );

  modport master (
    output s_init, out_busy, id, is, ks, os,
    input  s_fin, exec, k_init, k_fin, ia, wa, busy
  );

endinterface
`default_nettype wire

// File: rtl/core_ctrl_win_cnt.sv
`default_nettype none
// ============================================================================
// Module   : win_cnt
// Purpose  : Wrap counter for one level of the kernel loop nest. Loads i_ini
//            on i_start, steps on i_en, and wraps back to i_ini after i_fin.
//            o_last flags the final value so levels chain into a nest.
// Ports    : clk, rst_n     - clock, async active-low reset
//            i_start        - reload to i_ini (has priority over i_en)
//            i_en           - advance one step
//            i_ini, i_fin   - first and last count values
//            o_value        - current count
//            o_last         - o_value equals i_fin
// Revision : 1.0 - initial release
// ============================================================================
module win_cnt #(
  parameter int W = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         i_start,
  input  wire logic         i_en,
  input  wire logic [W-1:0] i_ini,
  input  wire logic [W-1:0] i_fin,
  output logic      [W-1:0] o_value,
  output logic              o_last
);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_start) begin
      r_value <= i_ini;
    end else if (i_en) begin
      r_value <= o_last ? i_ini : r_value + W'(1);
    end
  end

  assign o_value = r_value;
  assign o_last  = (r_value == i_fin);

endmodule
`default_nettype wire

// File: rtl/core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl
// Purpose  : Kernel-loop sequencer. On s_init it sweeps every output pixel
//            (oy, ox) and, per pixel, every (c, ky, kx) tap, issuing one MAC
//            tap per cycle with input address ia and weight address wa.
//            k_init/k_fin bracket each pixel; out_busy can hold off the
//            start of a pixel; s_fin reports completion to batch_ctrl.
// Ports    : clk    - clock
//            rst_n  - async active-low reset
//            ctrl   - core_ctrl_if slave (handshake, config, address bus)
// Revision : 1.0 - initial release
// ============================================================================
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int WW = WW_DEF
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  core_ctrl_if.slave ctrl
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;   // s_init taken in IDLE
  logic w_emit;     // a tap is issued at this edge

  // Configuration held for the whole pass
  logic [CH_W-1:0]   r_id;
  logic [SIDE_W-1:0] r_is;
  logic [KS_W-1:0]   r_ks;
  logic [SIDE_W-1:0] r_os;

  // Loop-nest counter values and wrap flags
  logic [KS_W-1:0]   w_kx, w_ky;
  logic [CH_W-1:0]   w_c;
  logic [SIDE_W-1:0] w_ox, w_oy;
  logic w_kx_last, w_ky_last, w_c_last, w_ox_last, w_oy_last;

  logic w_boundary;  // current tap is tap 0 of a pixel
  logic w_pix_last;  // current tap is the last tap of a pixel
  logic w_final;     // current tap is the last tap of the pass

  logic [AW-1:0] w_ia;
  logic [WW-1:0] w_wa;
  logic [WW-1:0] r_tap;

  logic          r_exec, r_k_init, r_k_fin, r_s_fin, r_busy;
  logic [AW-1:0] r_ia;
  logic [WW-1:0] r_wa;

  // --------------------------------------------------------------------------
  // Loop nest, inner to outer: kx, ky, c, ox, oy
  // --------------------------------------------------------------------------
  win_cnt #(.W(KS_W)) u_cnt_kx (
    .clk(clk), .rst_n(rst_n), .i_start(w_accept), .i_en(w_emit),
    .i_ini('0), .i_fin(r_ks), .o_value(w_kx), .o_last(w_kx_last)
  );

  win_cnt #(.W(KS_W)) u_cnt_ky (
    .clk(clk), .rst_n(rst_n), .i_start(w_accept), .i_en(w_emit & w_kx_last),
    .i_ini('0), .i_fin(r_ks), .o_value(w_ky), .o_last(w_ky_last)
  );

  win_cnt #(.W(CH_W)) u_cnt_c (
    .clk(clk), .rst_n(rst_n), .i_start(w_accept),
    .i_en(w_emit & w_kx_last & w_ky_last),
    .i_ini('0), .i_fin(r_id), .o_value(w_c), .o_last(w_c_last)
  );

  win_cnt #(.W(SIDE_W)) u_cnt_ox (
    .clk(clk), .rst_n(rst_n), .i_start(w_accept), .i_en(w_emit & w_pix_last),
    .i_ini('0), .i_fin(r_os), .o_value(w_ox), .o_last(w_ox_last)
  );

  win_cnt #(.W(SIDE_W)) u_cnt_oy (
    .clk(clk), .rst_n(rst_n), .i_start(w_accept),
    .i_en(w_emit & w_pix_last & w_ox_last),
    .i_ini('0), .i_fin(r_os), .o_value(w_oy), .o_last(w_oy_last)
  );

  assign w_boundary = (w_c == '0) && (w_ky == '0) && (w_kx == '0);
  assign w_pix_last = w_kx_last & w_ky_last & w_c_last;
  assign w_final    = w_pix_last & w_ox_last & w_oy_last;

  // --------------------------------------------------------------------------
  // Address generation. Every term is taken modulo 2^AW, which equals
  // truncating the full-precision sum.
  // --------------------------------------------------------------------------
  assign w_ia = AW'(w_c) * AW'(r_is) * AW'(r_is)
              + (AW'(w_oy) + AW'(w_ky)) * AW'(r_is)
              + AW'(w_ox) + AW'(w_kx);

  // Tap index within the pixel; forced to 0 on the first tap of each pixel
  assign w_wa = w_boundary ? '0 : r_tap;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A stalled pixel is released on the same edge out_busy is seen low, so
  // the exec gap equals the number of cycles out_busy was sampled high.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ctrl.s_init) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_boundary && ctrl.out_busy) begin
          w_state_nxt = STALL;
        end else begin
          w_emit = 1'b1;
          if (w_final) begin
            w_state_nxt = DONE;
          end
        end
      end
      STALL: begin
        if (!ctrl.out_busy) begin
          w_emit      = 1'b1;
          w_state_nxt = w_final ? DONE : RUN;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs, tap index and configuration capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exec   <= 1'b0;
      r_k_init <= 1'b0;
      r_k_fin  <= 1'b0;
      r_ia     <= '0;
      r_wa     <= '0;
      r_s_fin  <= 1'b0;
      r_busy   <= 1'b0;
      r_tap    <= '0;
      r_id     <= '0;
      r_is     <= '0;
      r_ks     <= '0;
      r_os     <= '0;
    end else begin
      r_exec   <= w_emit;
      r_k_init <= w_emit & w_boundary;
      r_k_fin  <= w_emit & w_pix_last;
      r_s_fin  <= (r_state == DONE);
      // busy covers the final tap's exec cycle and drops as s_fin rises
      r_busy   <= (w_state_nxt != IDLE);
      if (w_emit) begin
        r_ia <= w_ia;
        r_wa <= w_wa;
      end
      if (w_accept) begin
        r_tap <= '0;
        r_id  <= ctrl.id;
        r_is  <= ctrl.is;
        r_ks  <= ctrl.ks;
        r_os  <= ctrl.os;
      end else if (w_emit) begin
        r_tap <= w_wa + WW'(1);
      end
    end
  end

  assign ctrl.exec   = r_exec;
  assign ctrl.k_init = r_k_init;
  assign ctrl.k_fin  = r_k_fin;
  assign ctrl.ia     = r_ia;
  assign ctrl.wa     = r_wa;
  assign ctrl.s_fin  = r_s_fin;
  assign ctrl.busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_ctrl
// Purpose  : Directed self-checking bench for core_ctrl.
// Ports    : (none)
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_ctrl;

  logic clk;
  logic rst_n;

  core_ctrl_if #(.AW(12), .WW(10)) bus ();

  core_ctrl #(.AW(12), .WW(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Per-pass capture
  logic [11:0] cap_ia  [0:63];
  logic [9:0]  cap_wa  [0:63];
  logic        cap_ki  [0:63];
  logic        cap_kf  [0:63];
  int          cap_cyc [0:63];
  int          n_exec, n_ki, n_kf, n_sfin, sfin_cyc;
  logic        timed_out;
  logic        busy_start, busy_at_sfin, exec_at_sfin;

  task automatic set_cfg(input int id, input int is, input int ks, input int os);
    bus.id = 4'(id);
    bus.is = 5'(is);
    bus.ks = 3'(ks);
    bus.os = 5'(os);
  endtask

  // Starts a pass and records every exec cycle until s_fin (bounded).
  // busy_at / mid_at / reinit_at are exec counts at which to raise
  // out_busy for busy_len cycles, pulse out_busy for one cycle, or pulse
  // s_init for one cycle; -1 disables.
  task automatic run_pass(input int busy_at, input int busy_len, input int mid_at,
                          input int reinit_at, input int max_cyc);
    int cyc;
    int busy_rem;
    bit busy_started, mid_active, mid_done, re_active, re_done, seen;
    n_exec = 0; n_ki = 0; n_kf = 0; n_sfin = 0; sfin_cyc = -1;
    timed_out = 1'b0; busy_rem = 0; busy_started = 0;
    mid_active = 0; mid_done = 0; re_active = 0; re_done = 0; seen = 0;
    busy_at_sfin = 1'b1; exec_at_sfin = 1'b1;
    bus.out_busy = 1'b0;
    bus.s_init = 1'b1;
    @(posedge clk); #1;
    bus.s_init = 1'b0;
    busy_start = bus.busy;
    cyc = 0;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.exec === 1'b1) begin
        if (n_exec < 64) begin
          cap_ia[n_exec]  = bus.ia;
          cap_wa[n_exec]  = bus.wa;
          cap_ki[n_exec]  = bus.k_init;
          cap_kf[n_exec]  = bus.k_fin;
          cap_cyc[n_exec] = cyc;
        end
        n_exec++;
        if (bus.k_init === 1'b1) n_ki++;
        if (bus.k_fin === 1'b1) n_kf++;
      end
      if (bus.s_fin === 1'b1) begin
        n_sfin++;
        sfin_cyc = cyc;
        busy_at_sfin = bus.busy;
        exec_at_sfin = bus.exec;
        seen = 1;
      end
      if (busy_rem > 0) begin
        busy_rem--;
        if (busy_rem == 0) bus.out_busy = 1'b0;
      end else if (!busy_started && busy_at >= 0 && n_exec == busy_at) begin
        busy_started = 1;
        busy_rem = busy_len;
        bus.out_busy = 1'b1;
      end
      if (mid_active) begin
        mid_active = 0;
        bus.out_busy = 1'b0;
      end else if (!mid_done && mid_at >= 0 && n_exec == mid_at) begin
        mid_active = 1;
        mid_done = 1;
        bus.out_busy = 1'b1;
      end
      if (re_active) begin
        re_active = 0;
        bus.s_init = 1'b0;
      end else if (!re_done && reinit_at >= 0 && n_exec == reinit_at) begin
        re_active = 1;
        re_done = 1;
        bus.s_init = 1'b1;
      end
    end
    if (!seen) timed_out = 1'b1;
    bus.s_init = 1'b0;
    bus.out_busy = 1'b0;
    // Idle tail: nothing further may be issued
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.s_fin === 1'b1) n_sfin++;
      if (bus.exec === 1'b1) n_exec++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_init = 1'b0; bus.out_busy = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.exec, bus.k_init, bus.k_fin, bus.s_fin, bus.busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.exec, bus.k_init, bus.k_fin, bus.s_fin, bus.busy});
    end
    checks++;
    if (bus.ia !== 12'd0 || bus.wa !== 10'd0) begin
      failures++;
      $display("FAIL reset_addr got ia=%0d wa=%0d want 0/0", bus.ia, bus.wa);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int idx [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 12, 13, 14, 15, 32, 33, 34, 35};
    int exp [16] = '{0, 1, 4, 5, 1, 2, 5, 6, 4, 5, 8, 9, 10, 11, 14, 15};
    set_cfg(0, 4, 1, 2);
    run_pass(-1, 0, -1, -1, 200);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b want=0", timed_out); end
    checks++;
    if (busy_start !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b want=1", busy_start); end
    checks++;
    if (n_exec != 36) begin failures++; $display("FAIL basic_exec_count got=%0d want=36", n_exec); end
    checks++;
    if (n_ki != 9 || n_kf != 9) begin failures++; $display("FAIL basic_kinit_kfin got=%0d/%0d want=9/9", n_ki, n_kf); end
    checks++;
    if (cap_cyc[0] != 1) begin failures++; $display("FAIL basic_first_exec_cyc got=%0d want=1", cap_cyc[0]); end
    checks++;
    if (cap_cyc[35] != 36) begin failures++; $display("FAIL basic_contiguous got=%0d want=36", cap_cyc[35]); end
    checks++;
    if (sfin_cyc != 37 || n_sfin != 1) begin
      failures++; $display("FAIL basic_sfin got cyc=%0d n=%0d want cyc=37 n=1", sfin_cyc, n_sfin);
    end
    checks++;
    if (busy_at_sfin !== 1'b0 || exec_at_sfin !== 1'b0) begin
      failures++; $display("FAIL basic_sfin_busy got busy=%b exec=%b want 0/0", busy_at_sfin, exec_at_sfin);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_ia[idx[i]] !== 12'(exp[i])) begin
        failures++; $display("FAIL basic_ia[%0d] got=%0d want=%0d", idx[i], cap_ia[idx[i]], exp[i]);
      end
    end
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (cap_wa[i] !== 10'(i % 4) || cap_ki[i] !== (i % 4 == 0) || cap_kf[i] !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL basic_tap[%0d] got wa=%0d ki=%b kf=%b want wa=%0d ki=%b kf=%b",
                 i, cap_wa[i], cap_ki[i], cap_kf[i], i % 4, (i % 4 == 0), (i % 4 == 3));
      end
    end
  endtask

  task automatic test_channels();
    set_cfg(1, 4, 0, 3);
    run_pass(-1, 0, -1, -1, 200);
    checks++;
    if (timed_out !== 1'b0 || n_exec != 32 || n_ki != 16 || n_kf != 16) begin
      failures++;
      $display("FAIL chan_counts got to=%b exec=%0d ki=%0d kf=%0d want 0/32/16/16", timed_out, n_exec, n_ki, n_kf);
    end
    checks++;
    if (cap_ia[0] !== 12'd0 || cap_ia[1] !== 12'd16 || cap_wa[0] !== 10'd0 || cap_wa[1] !== 10'd1) begin
      failures++;
      $display("FAIL chan_pix0 got ia=%0d,%0d wa=%0d,%0d want 0,16 0,1", cap_ia[0], cap_ia[1], cap_wa[0], cap_wa[1]);
    end
    checks++;
    if ({cap_ki[0], cap_kf[0], cap_ki[1], cap_kf[1]} !== 4'b1001) begin
      failures++;
      $display("FAIL chan_bracket got=%b want=1001", {cap_ki[0], cap_kf[0], cap_ki[1], cap_kf[1]});
    end
    checks++;
    if (cap_ia[10] !== 12'd5 || cap_ia[11] !== 12'd21 || cap_ia[30] !== 12'd15 || cap_ia[31] !== 12'd31) begin
      failures++;
      $display("FAIL chan_ia got=%0d,%0d,%0d,%0d want 5,21,15,31", cap_ia[10], cap_ia[11], cap_ia[30], cap_ia[31]);
    end
    checks++;
    if (sfin_cyc != 33) begin failures++; $display("FAIL chan_sfin got=%0d want=33", sfin_cyc); end
  endtask

  task automatic test_single_tap();
    set_cfg(0, 4, 0, 0);
    run_pass(-1, 0, -1, -1, 50);
    checks++;
    if (timed_out !== 1'b0 || n_exec != 1) begin
      failures++; $display("FAIL single_count got to=%b exec=%0d want 0/1", timed_out, n_exec);
    end
    checks++;
    if (cap_ki[0] !== 1'b1 || cap_kf[0] !== 1'b1 || cap_ia[0] !== 12'd0 || cap_wa[0] !== 10'd0) begin
      failures++;
      $display("FAIL single_tap got ki=%b kf=%b ia=%0d wa=%0d want 1 1 0 0", cap_ki[0], cap_kf[0], cap_ia[0], cap_wa[0]);
    end
    checks++;
    if (sfin_cyc != 2 || n_sfin != 1) begin
      failures++; $display("FAIL single_sfin got cyc=%0d n=%0d want 2/1", sfin_cyc, n_sfin);
    end
  endtask

  task automatic test_stall();
    set_cfg(0, 4, 1, 2);
    run_pass(4, 5, 6, -1, 200);
    checks++;
    if (timed_out !== 1'b0 || n_exec != 36) begin
      failures++; $display("FAIL stall_count got to=%b exec=%0d want 0/36", timed_out, n_exec);
    end
    checks++;
    if (cap_cyc[4] - cap_cyc[3] != 6) begin
      failures++; $display("FAIL stall_gap got=%0d want=6", cap_cyc[4] - cap_cyc[3]);
    end
    checks++;
    if (cap_ia[4] !== 12'd1 || cap_ki[4] !== 1'b1 || cap_wa[4] !== 10'd0) begin
      failures++; $display("FAIL stall_resume got ia=%0d ki=%b wa=%0d want 1 1 0", cap_ia[4], cap_ki[4], cap_wa[4]);
    end
    checks++;
    if (cap_cyc[7] - cap_cyc[5] != 2) begin
      failures++; $display("FAIL stall_midpixel got=%0d want=2", cap_cyc[7] - cap_cyc[5]);
    end
    checks++;
    if (sfin_cyc != 42 || cap_cyc[35] != 41) begin
      failures++; $display("FAIL stall_sfin got sfin=%0d last=%0d want 42/41", sfin_cyc, cap_cyc[35]);
    end
  endtask

  task automatic test_back_to_back_init();
    set_cfg(0, 4, 1, 2);
    run_pass(-1, 0, -1, 10, 200);
    checks++;
    if (timed_out !== 1'b0 || n_exec != 36 || n_sfin != 1) begin
      failures++;
      $display("FAIL reinit_count got to=%b exec=%0d sfin=%0d want 0/36/1", timed_out, n_exec, n_sfin);
    end
    checks++;
    if (sfin_cyc != 37 || cap_ia[10] !== 12'd6) begin
      failures++; $display("FAIL reinit_seq got sfin=%0d ia10=%0d want 37/6", sfin_cyc, cap_ia[10]);
    end
  endtask

  task automatic test_reset_midpass();
    int sfin_seen;
    set_cfg(0, 4, 1, 2);
    bus.s_init = 1'b1;
    @(posedge clk); #1;
    bus.s_init = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.exec, bus.k_init, bus.k_fin, bus.s_fin, bus.busy} !== 5'b0 || bus.ia !== 12'd0 || bus.wa !== 10'd0) begin
      failures++;
      $display("FAIL midreset_outputs got flags=%b ia=%0d wa=%0d want 00000 0 0",
               {bus.exec, bus.k_init, bus.k_fin, bus.s_fin, bus.busy}, bus.ia, bus.wa);
    end
    sfin_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.s_fin === 1'b1) sfin_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.s_fin === 1'b1 || bus.exec === 1'b1) sfin_seen++;
    end
    checks++;
    if (sfin_seen != 0) begin failures++; $display("FAIL midreset_no_sfin got=%0d want=0", sfin_seen); end
    run_pass(-1, 0, -1, -1, 200);
    checks++;
    if (timed_out !== 1'b0 || n_exec != 36 || cap_ia[0] !== 12'd0 || cap_ki[0] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_restart got to=%b exec=%0d ia0=%0d ki0=%b want 0/36/0/1",
               timed_out, n_exec, cap_ia[0], cap_ki[0]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_channels();
    test_single_tap();
    test_stall();
    test_back_to_back_init();
    test_reset_midpass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
